// File: rtl/reg_file_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : reg_file_pkg
// Description : Shared encodings for the load-tracking register file:
//               write-source select codes and load tracker state type.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package reg_file_pkg;

  // Write-source select encodings
  localparam logic [1:0] MS_ALU  = 2'd0;
  localparam logic [1:0] MS_REG  = 2'd1;
  localparam logic [1:0] MS_IMM  = 2'd2;
  localparam logic [1:0] MS_ZERO = 2'd3;

  // Outstanding-load tracker state
  typedef enum logic [0:0] {
    LD_IDLE = 1'b0,
    LD_BUSY = 1'b1
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_ld_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : reg_file_ld_if
// Description : Operand/write/load bus of the register file. The master
//               drives requests, the slave (register file) returns data.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface reg_file_ld_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              i_e;
  logic [ADDR_W-1:0] i_wsel;
  logic [1:0]        i_msel;
  logic [WIDTH-1:0]  i_alu;
  logic [WIDTH-1:0]  i_reg;
  logic [WIDTH-1:0]  i_imm;
  logic [ADDR_W-1:0] i_ra_addr;
  logic [ADDR_W-1:0] i_rb_addr;
  logic [WIDTH-1:0]  o_ra;
  logic [WIDTH-1:0]  o_rb;
  logic              i_ld_issue;
  logic [ADDR_W-1:0] i_ld_addr;
  logic              i_ld_done;
  logic [WIDTH-1:0]  i_ld_data;
  logic              o_ld_busy;
  logic              o_stall;
  logic              o_ld_drop;

  modport master (
    output i_e, i_wsel, i_msel, i_alu, i_reg, i_imm, i_ra_addr, i_rb_addr,
    output i_ld_issue, i_ld_addr, i_ld_done, i_ld_data,
    input  o_ra, o_rb, o_ld_busy, o_stall, o_ld_drop
  );

  modport slave (
    input  i_e, i_wsel, i_msel, i_alu, i_reg, i_imm, i_ra_addr, i_rb_addr,
    input  i_ld_issue, i_ld_addr, i_ld_done, i_ld_data,
    output o_ra, o_rb, o_ld_busy, o_stall, o_ld_drop
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_ld_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : ld_tracker
// Description : Single outstanding-load tracker. Holds the pending register,
//               a WAW cancel flag, produces the read interlock (stall), the
//               load write enable and the dropped-load pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module ld_tracker
  import reg_file_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_e,
  input  wire logic [ADDR_W-1:0] i_wsel,
  input  wire logic              i_ld_issue,
  input  wire logic [ADDR_W-1:0] i_ld_addr,
  input  wire logic              i_ld_done,
  input  wire logic [ADDR_W-1:0] i_ra_addr,
  input  wire logic [ADDR_W-1:0] i_rb_addr,
  output logic                   o_ld_busy,
  output logic                   o_stall,
  output logic                   o_ld_drop,
  output logic                   o_ld_we,
  output logic [ADDR_W-1:0]      o_pend_addr
);

  ld_state_t         r_state;
  logic [ADDR_W-1:0] r_pend;
  logic              r_cancel;
  logic              r_drop;

  logic w_busy;
  logic w_null;
  logic w_hit;
  logic w_cancel_now;
  logic w_done;

  assign w_busy       = (r_state == LD_BUSY);
  // A load into a hardwired-zero r0 has no architectural effect at all.
  assign w_null       = (ZERO_R0 != 0) && (r_pend == '0);
  assign w_hit        = i_e && (i_wsel == r_pend);
  // A normal write landing on the pending register in the same cycle as the
  // return still counts as a cancel: the normal write wins.
  assign w_cancel_now = r_cancel || w_hit;
  assign w_done       = w_busy && i_ld_done;

  assign o_ld_we     = w_done && !w_cancel_now && !w_null;
  assign o_ld_busy   = w_busy;
  assign o_ld_drop   = r_drop;
  assign o_pend_addr = r_pend;
  assign o_stall     = w_busy && !r_cancel && !w_null && !i_ld_done &&
                       ((i_ra_addr == r_pend) || (i_rb_addr == r_pend));

  // Load tracker FSM with pending address, cancel flag and drop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= LD_IDLE;
      r_pend   <= '0;
      r_cancel <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= w_done && w_cancel_now && !w_null;
      case (r_state)
        LD_IDLE: begin
          if (i_ld_issue) begin
            r_state  <= LD_BUSY;
            r_pend   <= i_ld_addr;
            r_cancel <= 1'b0;
          end
        end
        LD_BUSY: begin
          if (i_ld_done) begin
            r_cancel <= 1'b0;
            if (i_ld_issue) begin
              r_pend <= i_ld_addr;
            end else begin
              r_state <= LD_IDLE;
            end
          end else begin
            r_cancel <= w_cancel_now;
          end
        end
        default: r_state <= LD_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_ld.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : reg_file_ld
// Description : WIDTH x DEPTH register file with muxed write source, two
//               combinational read ports with optional write bypass, and a
//               single outstanding-load tracker with interlock.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module reg_file_ld
  import reg_file_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input wire logic    clk,
  input wire logic    rst,
  reg_file_ld_if.slave bus
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  w_wdata;
  logic              w_norm_we;
  logic              w_ld_we;
  logic [ADDR_W-1:0] w_pend;

  ld_tracker #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .i_e         (bus.i_e),
    .i_wsel      (bus.i_wsel),
    .i_ld_issue  (bus.i_ld_issue),
    .i_ld_addr   (bus.i_ld_addr),
    .i_ld_done   (bus.i_ld_done),
    .i_ra_addr   (bus.i_ra_addr),
    .i_rb_addr   (bus.i_rb_addr),
    .o_ld_busy   (bus.o_ld_busy),
    .o_stall     (bus.o_stall),
    .o_ld_drop   (bus.o_ld_drop),
    .o_ld_we     (w_ld_we),
    .o_pend_addr (w_pend)
  );

  // Write-source mux
  always_comb begin
    w_wdata = '0;
    case (bus.i_msel)
      MS_ALU:  w_wdata = bus.i_alu;
      MS_REG:  w_wdata = bus.i_reg;
      MS_IMM:  w_wdata = bus.i_imm;
      default: w_wdata = '0;
    endcase
  end

  assign w_norm_we = bus.i_e && !((ZERO_R0 != 0) && (bus.i_wsel == '0));

  // Read port: hardwired zero, then normal write, then load return, then array
  function automatic logic [WIDTH-1:0] f_read(
    input logic [ADDR_W-1:0] a,
    input logic [WIDTH-1:0]  stored,
    input logic              norm_we,
    input logic [ADDR_W-1:0] wsel,
    input logic [WIDTH-1:0]  wdata,
    input logic              ld_we,
    input logic [ADDR_W-1:0] pend,
    input logic [WIDTH-1:0]  ld_data
  );
    logic [WIDTH-1:0] v;
    v = stored;
    if (BYPASS != 0) begin
      if (ld_we && (pend == a))    v = ld_data;
      if (norm_we && (wsel == a))  v = wdata;
    end
    if ((ZERO_R0 != 0) && (a == '0)) v = '0;
    return v;
  endfunction

  assign bus.o_ra = f_read(bus.i_ra_addr, r_mem[bus.i_ra_addr], w_norm_we,
                           bus.i_wsel, w_wdata, w_ld_we, w_pend, bus.i_ld_data);
  assign bus.o_rb = f_read(bus.i_rb_addr, r_mem[bus.i_rb_addr], w_norm_we,
                           bus.i_wsel, w_wdata, w_ld_we, w_pend, bus.i_ld_data);

  // Storage update; normal write is applied last so it wins on a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_ld_we) begin
        r_mem[w_pend] <= bus.i_ld_data;
      end
      if (w_norm_we) begin
        r_mem[bus.i_wsel] <= w_wdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_ld.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_reg_file_ld
// Description : Scoreboard bench for reg_file_ld. Three configurations share
//               one stimulus stream: cfg0 bypass, cfg1 no bypass, cfg2 bypass
//               with hardwired r0.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_reg_file_ld;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus
  logic       e, ld_issue, ld_done;
  logic [2:0] wsel, ra_addr, rb_addr, ld_addr;
  logic [1:0] msel;
  logic [7:0] alu, regv, imm, ld_data;

  reg_file_ld_if #(.WIDTH(8), .ADDR_W(3)) if0 ();
  reg_file_ld_if #(.WIDTH(8), .ADDR_W(3)) if1 ();
  reg_file_ld_if #(.WIDTH(8), .ADDR_W(3)) if2 ();

  assign if0.i_e = e;        assign if1.i_e = e;        assign if2.i_e = e;
  assign if0.i_wsel = wsel;  assign if1.i_wsel = wsel;  assign if2.i_wsel = wsel;
  assign if0.i_msel = msel;  assign if1.i_msel = msel;  assign if2.i_msel = msel;
  assign if0.i_alu = alu;    assign if1.i_alu = alu;    assign if2.i_alu = alu;
  assign if0.i_reg = regv;   assign if1.i_reg = regv;   assign if2.i_reg = regv;
  assign if0.i_imm = imm;    assign if1.i_imm = imm;    assign if2.i_imm = imm;
  assign if0.i_ra_addr = ra_addr; assign if1.i_ra_addr = ra_addr; assign if2.i_ra_addr = ra_addr;
  assign if0.i_rb_addr = rb_addr; assign if1.i_rb_addr = rb_addr; assign if2.i_rb_addr = rb_addr;
  assign if0.i_ld_issue = ld_issue; assign if1.i_ld_issue = ld_issue; assign if2.i_ld_issue = ld_issue;
  assign if0.i_ld_addr = ld_addr;   assign if1.i_ld_addr = ld_addr;   assign if2.i_ld_addr = ld_addr;
  assign if0.i_ld_done = ld_done;   assign if1.i_ld_done = ld_done;   assign if2.i_ld_done = ld_done;
  assign if0.i_ld_data = ld_data;   assign if1.i_ld_data = ld_data;   assign if2.i_ld_data = ld_data;

  reg_file_ld #(.WIDTH(8), .DEPTH(8), .BYPASS(1), .ZERO_R0(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  reg_file_ld #(.WIDTH(8), .DEPTH(8), .BYPASS(0), .ZERO_R0(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  reg_file_ld #(.WIDTH(8), .DEPTH(8), .BYPASS(1), .ZERO_R0(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // ---------------- reference model ----------------
  logic [7:0] m_mem [3][8];
  bit         m_busy [3];
  bit         m_cancel [3];
  bit         m_drop [3];
  int         m_pend [3];

  function automatic bit byp(int c); return (c != 1); endfunction
  function automatic bit zr(int c);  return (c == 2); endfunction

  function automatic logic [7:0] src_val();
    case (msel)
      2'd0: return alu;
      2'd1: return regv;
      2'd2: return imm;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] m_read(int c, int a);
    bit canc;
    canc = m_cancel[c] || (e && int'(wsel) == m_pend[c]);
    if (zr(c) && a == 0) return 8'h00;
    if (byp(c)) begin
      if (e && int'(wsel) == a) return src_val();
      if (m_busy[c] && ld_done && m_pend[c] == a && !canc) return ld_data;
    end
    return m_mem[c][a];
  endfunction

  task automatic m_step(int c);
    bit canc, nul, done;
    canc = m_cancel[c] || (e && int'(wsel) == m_pend[c]);
    nul  = zr(c) && m_pend[c] == 0;
    done = m_busy[c] && ld_done;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_mem[c][i] = 8'h00;
      m_busy[c] = 0; m_cancel[c] = 0; m_drop[c] = 0; m_pend[c] = 0;
      return;
    end
    m_drop[c] = done && canc && !nul;
    if (done && !canc && !nul) m_mem[c][m_pend[c]] = ld_data;
    if (e && !(zr(c) && wsel == 3'd0)) m_mem[c][wsel] = src_val();
    if (!m_busy[c]) begin
      if (ld_issue) begin m_busy[c] = 1; m_pend[c] = int'(ld_addr); m_cancel[c] = 0; end
    end else if (ld_done) begin
      m_cancel[c] = 0;
      if (ld_issue) m_pend[c] = int'(ld_addr);
      else m_busy[c] = 0;
    end else begin
      m_cancel[c] = canc;
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [2:0][7:0] ra;
    logic [2:0][7:0] rb;
    logic [2:0]      busy;
    logic [2:0]      stall;
    logic [2:0]      drop;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic tick(bit chk);
    exp_t x;
    if (chk) begin
      for (int c = 0; c < 3; c++) begin
        x.ra[c]    = m_read(c, int'(ra_addr));
        x.rb[c]    = m_read(c, int'(rb_addr));
        x.busy[c]  = m_busy[c];
        x.drop[c]  = m_drop[c];
        x.stall[c] = m_busy[c] && !m_cancel[c] && !(zr(c) && m_pend[c] == 0) && !ld_done &&
                     (int'(ra_addr) == m_pend[c] || int'(rb_addr) == m_pend[c]);
      end
      exp_q.push_back(x);
    end
    @(posedge clk);
    for (int c = 0; c < 3; c++) m_step(c);
    #1;
  endtask

  task automatic cmp(string nm, int c, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cfg%0d t=%0t actual=%h required=%h", nm, c, $time, act, req);
    end
  endtask

  logic [7:0] a_ra [3], a_rb [3];
  logic       a_busy [3], a_stall [3], a_drop [3];
  assign a_ra[0] = if0.o_ra; assign a_ra[1] = if1.o_ra; assign a_ra[2] = if2.o_ra;
  assign a_rb[0] = if0.o_rb; assign a_rb[1] = if1.o_rb; assign a_rb[2] = if2.o_rb;
  assign a_busy[0] = if0.o_ld_busy; assign a_busy[1] = if1.o_ld_busy; assign a_busy[2] = if2.o_ld_busy;
  assign a_stall[0] = if0.o_stall;  assign a_stall[1] = if1.o_stall;  assign a_stall[2] = if2.o_stall;
  assign a_drop[0] = if0.o_ld_drop; assign a_drop[1] = if1.o_ld_drop; assign a_drop[2] = if2.o_ld_drop;

  // Monitor: outputs are valid every cycle; sample mid-cycle on the falling edge
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      for (int c = 0; c < 3; c++) begin
        cmp("ra",    c, a_ra[c], x.ra[c]);
        cmp("rb",    c, a_rb[c], x.rb[c]);
        cmp("busy",  c, {7'd0, a_busy[c]},  {7'd0, x.busy[c]});
        cmp("stall", c, {7'd0, a_stall[c]}, {7'd0, x.stall[c]});
        cmp("drop",  c, {7'd0, a_drop[c]},  {7'd0, x.drop[c]});
      end
    end
  end

  task automatic idle();
    e = 0; ld_issue = 0; ld_done = 0; rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    wsel = 0; msel = 0; alu = 0; regv = 0; imm = 0;
    ra_addr = 0; rb_addr = 0; ld_addr = 0; ld_data = 0;
    for (int c = 0; c < 3; c++) m_pend[c] = 0;
    rst = 1;
    tick(0);
    rst = 0;

    // reset then immediate write to r3, then sweep all registers
    e = 1; wsel = 3; msel = 2; imm = 8'h7B; ra_addr = 1; rb_addr = 2;
    tick(1);
    idle(); ra_addr = 3;
    tick(1);
    for (int a = 0; a < 8; a++) begin
      ra_addr = 3'(a); rb_addr = 3'(7 - a);
      tick(1);
    end

    // same-cycle bypass of an ALU write
    e = 1; wsel = 5; msel = 0; alu = 8'hA5; ra_addr = 5;
    tick(1);
    idle();
    tick(1);

    // load interlock on r2
    ld_issue = 1; ld_addr = 2;
    tick(1);
    idle(); rb_addr = 2;
    tick(1); tick(1); tick(1);
    ld_done = 1; ld_data = 8'h3C;
    tick(1);
    idle();
    tick(1);

    // WAW cancel on r4
    ld_issue = 1; ld_addr = 4;
    tick(1);
    idle(); e = 1; wsel = 4; msel = 2; imm = 8'h11; ra_addr = 4;
    tick(1);
    idle(); ld_done = 1; ld_data = 8'hFF;
    tick(1);
    idle();
    tick(1); tick(1);

    // back-to-back load, then reset while busy
    ld_issue = 1; ld_addr = 1;
    tick(1);
    idle(); ld_done = 1; ld_data = 8'h42; ld_issue = 1; ld_addr = 6; ra_addr = 6; rb_addr = 1;
    tick(1);
    idle();
    tick(1);
    rst = 1;
    tick(1);
    idle(); ld_done = 1; ld_data = 8'h99;
    tick(1);
    idle();
    tick(1);

    // hardwired r0 write and load
    e = 1; wsel = 0; msel = 2; imm = 8'h55; ra_addr = 0;
    tick(1);
    idle();
    tick(1);
    ld_issue = 1; ld_addr = 0;
    tick(1);
    idle(); rb_addr = 0;
    tick(1);
    ld_done = 1; ld_data = 8'h77;
    tick(1);
    idle();
    tick(1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      e        = ($urandom_range(0, 1) == 1);
      wsel     = 3'($urandom_range(0, 7));
      msel     = 2'($urandom_range(0, 3));
      alu      = 8'($urandom);
      regv     = 8'($urandom);
      imm      = 8'($urandom);
      ra_addr  = 3'($urandom_range(0, 7));
      rb_addr  = 3'($urandom_range(0, 7));
      ld_issue = ($urandom_range(0, 3) == 0);
      ld_addr  = 3'($urandom_range(0, 7));
      ld_done  = ($urandom_range(0, 2) == 0);
      ld_data  = 8'($urandom);
      tick(1);
    end
    idle();
    tick(1);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending entries", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
